serial_add_sequencer: RTL

SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/serial_add_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial add sequencer.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder.
// Sits outside the sequencer and is wired to it through the fa_* ports.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer: shifts operands LSB-first through an
// external full adder and assembles the sum over WIDTH cycles.
module serial_add_sequencer
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_c,
   input  logic             fa_sum,
   input  logic             fa_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;

   // State register; reset wins over every handshake input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/adder-port decode.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      fa_a      = 1'b0;
      fa_b      = 1'b0;
      fa_c      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            fa_a = a_q[0];
            fa_b = b_q[0];
            fa_c = carry_q;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand load at accept, one serial step per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  carry_q <= in_cin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
               carry_q <= fa_carry;
               if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign out_sum  = sum_q;
   assign out_cout = carry_q;

endmodule
